ctr_seq_checker: RTL and testbench



---
 rtl/ctr_chk_pkg.sv | 26 ++
 rtl/ctr_seq_checker_sat_counter.sv | 46 ++++
 rtl/ctr_seq_checker.sv | 185 ++++++++++++++++++
 tb/tb_ctr_seq_checker.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctr_chk_pkg.sv
// ---------------------------------------------------------------------------
// ctr_chk_pkg
// Shared types and constants for the counter sequence checker.
//   chk_state_e : checker FSM states (IDLE / ACQUIRE / LOCKED)
//   CNT_W       : width of the small run/miss counters (LOCK_CNT and
//                 MAX_MISS are limited to 1..15, so 4 bits always suffice)
//   small_cnt_t : convenience type for those counters
// ---------------------------------------------------------------------------
package ctr_chk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } chk_state_e;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] small_cnt_t;

    // Increment of a run/miss counter; callers guarantee it never exceeds 15.
    function automatic small_cnt_t small_inc(input small_cnt_t v);
        return v + small_cnt_t'(1);
    endfunction

endpackage

// File: rtl/ctr_seq_checker_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter with optional saturation at all-ones.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears the count
//   clr    : synchronous clear (priority over inc)
//   inc    : increment request for this cycle
//   sat_en : 1 = hold at all-ones, 0 = roll over to zero
//   value  : current count (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             sat_en,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (!(sat_en && (cnt_q == {WIDTH{1'b1}}))) begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;

endmodule

// File: rtl/ctr_seq_checker.sv
// ---------------------------------------------------------------------------
// ctr_seq_checker
// Passive monitor for a free-running N-bit up-counter. Acquires lock on the
// +1 sequence, then tracks it with a shadow counter, flagging and counting
// every out-of-sequence sample and every matched wrap to zero.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset of all state and statistics
//   ctr_reset  : observed counter's reset (active-high, sampled on clk)
//   count      : observed counter value
//   locked     : high while in LOCKED
//   err_pulse  : one-cycle pulse per mismatched sample while LOCKED
//   err_seen   : sticky, set by the first mismatch
//   err_count  : mismatch count, saturating at 2^E-1
//   wrap_count : matched wraps from 2^N-1 to 0, rolls over at 2^W
//   first_exp  : shadow (expected) value at the first mismatch
//   first_obs  : observed value at the first mismatch
// All outputs are registered.
// ---------------------------------------------------------------------------
module ctr_seq_checker
    import ctr_chk_pkg::*;
#(
    parameter int N        = 4,
    parameter int LOCK_CNT = 2,
    parameter int MAX_MISS = 3,
    parameter int E        = 8,
    parameter int W        = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ctr_reset,
    input  logic [N-1:0] count,
    output logic         locked,
    output logic         err_pulse,
    output logic         err_seen,
    output logic [E-1:0] err_count,
    output logic [W-1:0] wrap_count,
    output logic [N-1:0] first_exp,
    output logic [N-1:0] first_obs
);

    localparam logic [N-1:0] ONE_N  = N'(1);
    localparam small_cnt_t   LOCK_V = small_cnt_t'(LOCK_CNT);
    localparam small_cnt_t   MISS_V = small_cnt_t'(MAX_MISS);

    chk_state_e   state_q, state_d;
    logic [N-1:0] prev_q, prev_d;
    logic [N-1:0] shadow_q, shadow_d;
    small_cnt_t   run_q, run_d;
    small_cnt_t   miss_q, miss_d;
    logic         err_pulse_q, err_pulse_d;
    logic         err_seen_q, err_seen_d;
    logic [N-1:0] first_exp_q, first_exp_d;
    logic [N-1:0] first_obs_q, first_obs_d;
    logic [W-1:0] wrap_q, wrap_d;
    logic         err_inc;
    logic         step_ok;
    logic         match;

    // Sequence continuity in ACQUIRE, and shadow agreement in LOCKED.
    assign step_ok = (count == (prev_q + ONE_N));
    assign match   = (count == shadow_q);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        shadow_d    = shadow_q;
        run_d       = run_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_seen_d  = err_seen_q;
        first_exp_d = first_exp_q;
        first_obs_d = first_obs_q;
        wrap_d      = wrap_q;
        err_inc     = 1'b0;

        if (ctr_reset) begin
            // The counter is being reset: drop tracking but keep statistics.
            // This also masks any mismatch sampled in the same cycle.
            state_d  = IDLE;
            run_d    = '0;
            miss_d   = '0;
            shadow_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    prev_d  = count;
                    run_d   = '0;
                end

                ACQUIRE: begin
                    run_d  = step_ok ? small_inc(run_q) : '0;
                    prev_d = count;
                    if (run_d == LOCK_V) begin
                        state_d  = LOCKED;
                        shadow_d = count + ONE_N;
                        miss_d   = '0;
                    end
                end

                LOCKED: begin
                    // The shadow free-runs; it is never resynced to a bad
                    // sample, so an isolated glitch costs exactly one error.
                    shadow_d = shadow_q + ONE_N;
                    if (match) begin
                        miss_d = '0;
                        if (count == '0) begin
                            wrap_d = wrap_q + W'(1);
                        end
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        miss_d      = small_inc(miss_q);
                        if (!err_seen_q) begin
                            err_seen_d  = 1'b1;
                            first_exp_d = shadow_q;
                            first_obs_d = count;
                        end
                        // Too many misses in a row: fall back and re-acquire,
                        // starting from the sample that broke lock.
                        if (miss_d == MISS_V) begin
                            state_d = ACQUIRE;
                            prev_d  = count;
                            run_d   = '0;
                            miss_d  = '0;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                    miss_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            shadow_q    <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_seen_q  <= 1'b0;
            first_exp_q <= '0;
            first_obs_q <= '0;
            wrap_q      <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            shadow_q    <= shadow_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
            err_seen_q  <= err_seen_d;
            first_exp_q <= first_exp_d;
            first_obs_q <= first_obs_d;
            wrap_q      <= wrap_d;
        end
    end

    // Error statistics are only cleared by the block reset.
    sat_counter #(
        .WIDTH (E)
    ) u_err_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .clr    (1'b0),
        .inc    (err_inc),
        .sat_en (1'b1),
        .value  (err_count)
    );

    assign locked     = (state_q == LOCKED);
    assign err_pulse  = err_pulse_q;
    assign err_seen   = err_seen_q;
    assign wrap_count = wrap_q;
    assign first_exp  = first_exp_q;
    assign first_obs  = first_obs_q;

endmodule

// File: tb/tb_ctr_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_ctr_seq_checker
// Two checkers (E=8 and E=2) watch the same driven counter stream. A
// behavioural model of the sequence rules predicts every output after every
// edge; literal expectations at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_ctr_seq_checker;

    localparam int N        = 4;
    localparam int LOCK_CNT = 2;
    localparam int MAX_MISS = 3;
    localparam int E        = 8;
    localparam int E2       = 2;
    localparam int W        = 16;
    localparam int MODN     = 1 << N;

    logic          clk = 1'b0;
    logic          reset;
    logic          ctr_reset;
    logic [N-1:0]  count;

    logic          a_locked, a_err_pulse, a_err_seen;
    logic [E-1:0]  a_err_count;
    logic [W-1:0]  a_wrap_count;
    logic [N-1:0]  a_first_exp, a_first_obs;

    logic          b_locked, b_err_pulse, b_err_seen;
    logic [E2-1:0] b_err_count;
    logic [W-1:0]  b_wrap_count;
    logic [N-1:0]  b_first_exp, b_first_obs;

    int checks   = 0;
    int failures = 0;
    int cval     = 0;

    // model: 0 = idle, 1 = acquiring, 2 = locked
    int m_state, m_prev, m_run, m_shadow, m_miss;
    int m_errs, m_wraps, m_seen, m_fexp, m_fobs, m_pulse;

    always #5 clk = ~clk;

    ctr_seq_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .MAX_MISS(MAX_MISS), .E(E), .W(W)) dut_a (
        .clk(clk), .reset(reset), .ctr_reset(ctr_reset), .count(count),
        .locked(a_locked), .err_pulse(a_err_pulse), .err_seen(a_err_seen),
        .err_count(a_err_count), .wrap_count(a_wrap_count),
        .first_exp(a_first_exp), .first_obs(a_first_obs)
    );

    ctr_seq_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .MAX_MISS(MAX_MISS), .E(E2), .W(W)) dut_b (
        .clk(clk), .reset(reset), .ctr_reset(ctr_reset), .count(count),
        .locked(b_locked), .err_pulse(b_err_pulse), .err_seen(b_err_seen),
        .err_count(b_err_count), .wrap_count(b_wrap_count),
        .first_exp(b_first_exp), .first_obs(b_first_obs)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_state = 0; m_prev = 0; m_run = 0; m_shadow = 0; m_miss = 0;
        m_errs = 0; m_wraps = 0; m_seen = 0; m_fexp = 0; m_fobs = 0; m_pulse = 0;
    endtask

    // One sampled clock edge of the sequence rules.
    task automatic model_edge(input bit cr, input int c);
        m_pulse = 0;
        if (cr) begin
            m_state = 0; m_run = 0; m_miss = 0; m_shadow = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_prev = c; m_run = 0;
        end else if (m_state == 1) begin
            m_run  = (c == (m_prev + 1) % MODN) ? m_run + 1 : 0;
            m_prev = c;
            if (m_run >= LOCK_CNT) begin
                m_state  = 2;
                m_shadow = (c + 1) % MODN;
                m_miss   = 0;
            end
        end else begin
            if (c == m_shadow) begin
                m_miss = 0;
                if (c == 0) m_wraps++;
            end else begin
                m_pulse = 1;
                m_errs++;
                m_miss++;
                if (m_seen == 0) begin
                    m_seen = 1; m_fexp = m_shadow; m_fobs = c;
                end
                if (m_miss >= MAX_MISS) begin
                    m_state = 1; m_prev = c; m_run = 0; m_miss = 0;
                end
            end
            m_shadow = (m_shadow + 1) % MODN;
        end
    endtask

    function automatic int sat(input int v, input int w);
        int top;
        top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    task automatic compare_all();
        chk("a_locked",     32'(a_locked),     32'(m_state == 2));
        chk("a_err_pulse",  32'(a_err_pulse),  32'(m_pulse));
        chk("a_err_seen",   32'(a_err_seen),   32'(m_seen));
        chk("a_err_count",  32'(a_err_count),  32'(sat(m_errs, E)));
        chk("a_wrap_count", 32'(a_wrap_count), 32'(m_wraps % (1 << W)));
        chk("a_first_exp",  32'(a_first_exp),  32'(m_fexp));
        chk("a_first_obs",  32'(a_first_obs),  32'(m_fobs));
        chk("b_locked",     32'(b_locked),     32'(m_state == 2));
        chk("b_err_pulse",  32'(b_err_pulse),  32'(m_pulse));
        chk("b_err_seen",   32'(b_err_seen),   32'(m_seen));
        chk("b_err_count",  32'(b_err_count),  32'(sat(m_errs, E2)));
        chk("b_wrap_count", 32'(b_wrap_count), 32'(m_wraps % (1 << W)));
        chk("b_first_exp",  32'(b_first_exp),  32'(m_fexp));
        chk("b_first_obs",  32'(b_first_obs),  32'(m_fobs));
    endtask

    // Drive one sample, let the edge happen, then check just after it.
    task automatic step(input bit cr, input int c);
        ctr_reset = cr;
        count     = N'(c);
        @(posedge clk);
        if (reset) model_edge(cr, c % MODN);
        else       model_clear();
        #1;
        compare_all();
    endtask

    task automatic run_ctr(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, cval % MODN);
            cval++;
        end
    endtask

    initial begin
        reset     = 1'b0;
        ctr_reset = 1'b1;
        count     = '0;
        model_clear();

        // reset state
        #2;
        chk("rst_locked", 32'(a_locked), 0);
        chk("rst_err_count", 32'(a_err_count), 0);
        compare_all();
        step(1'b1, 0);
        step(1'b1, 0);
        #3 reset = 1'b1;
        step(1'b1, 0);
        step(1'b1, 0);

        // lock acquisition: samples 0,1 -> not yet; sample 2 -> locked
        cval = 0;
        run_ctr(2);
        chk("lock_not_yet", 32'(a_locked), 0);
        run_ctr(1);
        chk("lock_after_2_steps", 32'(a_locked), 1);

        // clean run through two wraps (samples 16 and 32 are zero)
        run_ctr(37);
        chk("wrap_twice", 32'(a_wrap_count), 2);
        chk("no_errors", 32'(a_err_count), 0);

        // single glitch: 9 where 5 is expected
        while (cval % MODN != 5) run_ctr(1);
        step(1'b0, 9);
        cval++;
        chk("glitch_pulse", 32'(a_err_pulse), 1);
        chk("glitch_err_count", 32'(a_err_count), 1);
        chk("glitch_first_exp", 32'(a_first_exp), 5);
        chk("glitch_first_obs", 32'(a_first_obs), 9);
        chk("glitch_keeps_lock", 32'(a_locked), 1);
        run_ctr(1);
        chk("glitch_pulse_once", 32'(a_err_pulse), 0);
        chk("glitch_resumes", 32'(a_locked), 1);
        run_ctr(4);

        // three consecutive bad samples drop lock
        for (int k = 0; k < 3; k++) begin
            step(1'b0, (cval + 7) % MODN);
            cval++;
            if (k < 2) chk("burst_still_locked", 32'(a_locked), 1);
        end
        chk("burst_lock_lost", 32'(a_locked), 0);
        chk("burst_err_pulse", 32'(a_err_pulse), 1);
        chk("burst_err_count", 32'(a_err_count), 4);
        chk("burst_first_kept", 32'(a_first_obs), 9);
        run_ctr(2);
        chk("relock_pending", 32'(a_locked), 0);
        run_ctr(1);
        chk("relocked", 32'(a_locked), 1);
        run_ctr(3);

        // ctr_reset with a simultaneous bad value: no error, go idle
        step(1'b1, 11);
        chk("ctr_rst_no_pulse", 32'(a_err_pulse), 0);
        chk("ctr_rst_unlocked", 32'(a_locked), 0);
        step(1'b1, 0);
        chk("ctr_rst_stats_kept", 32'(a_err_count), 4);
        cval = 0;
        run_ctr(3);
        chk("ctr_rst_relock", 32'(a_locked), 1);

        // five isolated errors: E=2 instance saturates at 3
        for (int k = 0; k < 5; k++) begin
            run_ctr(3);
            step(1'b0, (cval + 5) % MODN);
            cval++;
        end
        chk("iso_err_count_e8", 32'(a_err_count), 9);
        chk("iso_err_count_e2", 32'(b_err_count), 3);
        chk("iso_first_exp", 32'(b_first_exp), 5);
        chk("iso_first_obs", 32'(b_first_obs), 9);
        chk("iso_still_locked", 32'(a_locked), 1);
        run_ctr(5);

        // asynchronous reset between edges while locked
        #2 reset = 1'b0;
        #1;
        chk("async_locked", 32'(a_locked), 0);
        chk("async_err_seen", 32'(a_err_seen), 0);
        chk("async_err_count", 32'(a_err_count), 0);
        chk("async_wrap", 32'(a_wrap_count), 0);
        chk("async_first_exp", 32'(a_first_exp), 0);
        chk("async_first_obs", 32'(a_first_obs), 0);
        chk("async_b_err_count", 32'(b_err_count), 0);
        model_clear();
        compare_all();
        step(1'b0, 3);
        #3 reset = 1'b1;
        step(1'b1, 0);
        cval = 0;
        run_ctr(4);
        chk("post_reset_lock", 32'(a_locked), 1);
        chk("post_reset_clean", 32'(a_err_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
